mul_stage_pipe: RTL and testbench
=================================

Name: mul_stage_pipe

Overview:
- Parametrised N-channel multiply pipeline stage: per channel, computes c*p and forwards the c operand alongside the product.
- Generalises the fixed 9-channel 8x8 multiply stage: configurable channel count, width and latency.
- Adds valid/ready flow control with back-pressure stall.
- Adds a per-packet multiply-accumulate mode.
- Sits between the coefficient-fetch stage and the summation stage of the filter pipeline.

Parameters:
- N_CH, 9, number of parallel channels.
- DATA_W, 8, unsigned operand width for c and p.
- LAT, 2, cycles from accepted input to output register (must be >=1).
- ACC_GUARD, 4, extra accumulator bits; ACC_W = 2*DATA_W + ACC_GUARD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_last  in  1  last beat of an accumulate packet (ignored when in_mode=0).
- in_mode  in  1  0 = plain multiply, 1 = multiply-accumulate.
- c_in  in  N_CH*DATA_W  packed c operands; channel k at bits [k*DATA_W +: DATA_W].
- p_in  in  N_CH*DATA_W  packed p operands, same packing as c_in.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_last  out  1  beat closes an accumulate packet.
- c_out  out  N_CH*DATA_W  c operands delayed to align with cp_out.
- cp_out  out  N_CH*ACC_W  per-channel product or accumulated sum.

Behaviour:
- Reset: all pipeline valid bits, out_valid, out_last, c_out, cp_out, the accumulators and the first-beat flag clear to 0. A beat in flight during reset is discarded, and an accumulate packet in progress is abandoned.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance, combinational; it does not depend on in_valid.
  - A beat is accepted when in_valid & in_ready.
  - When advance=0 every stage holds its contents and the output stays stable.
- Pipeline:
  - Products are formed unsigned as 2*DATA_W bits.
  - Products travel LAT-1 product registers, then the final output/accumulate register.
  - With LAT=1, multiply and final register occur in the same cycle.
  - c, mode and last travel with their beat as sideband.
  - An accepted beat reaches the output register LAT advancing cycles after acceptance.
  - Bubbles, i.e. invalid slots, propagate like beats.
- Mode 0:
  - cp_out[k] = zero-extended c*p; out_last = 0.
  - Each beat produces one output beat.
  - The accumulators are untouched.
- Mode 1:
  - At the final stage, acc[k] = (first ? 0 : acc[k]) + product[k].
  - first is set at reset and after any mode-1 last beat. It clears on any non-last mode-1 beat.
  - Non-last beats update acc only and produce no output beat (out_valid stays 0 for that slot).
  - The last beat drives cp_out = updated acc, out_last = 1, out_valid = 1, and c_out = that beat's c.
  - A single-beat packet (first & last) outputs its product.
- A mode-0 beat arriving mid-packet passes through as a plain product. It does not disturb acc or first.
- Overflow: the accumulator wraps modulo 2^ACC_W.
- Throughput is 1 beat/cycle when out_ready=1.
- No combinational path from in_valid or data to out_*.

Optional Feature:
- Macro: MUL_STAGE_SAT_EN.
- Defined:
  - An accumulate result that would exceed 2^ACC_W-1 clamps to all-ones.
  - Clamping is sticky for the rest of the packet.
  - Each channel clamps independently.
- Undefined: the accumulator wraps modulo 2^ACC_W. The saturation logic is absent.

Test Plan:
- Reset/idle, defaults, LAT=2: assert rst for 2 cycles with in_valid=1 -> out_valid=0, cp_out=0, c_out=0; in_ready=1 once reset releases.
- Mode 0, LAT=2: ch0 c=255, p=255 and ch8 c=3, p=7 accepted at cycle t -> out_valid at t+2, cp_out ch0=65025, ch8=21, c_out ch0=255, out_last=0.
- Back-pressure: stream 5 beats with out_ready held low from the first output -> output frozen, in_ready=0, no beats lost; release -> 5 outputs appear in order.
- Accumulate packet: mode=1, ch0 products 10*10, 20*3, 1*1 with last on beat 3 -> exactly one output, cp_out ch0=161, out_last=1; the next packet starts from 0.
- Interleave: mode-0 beat 4*5 inserted mid-packet -> output 20, and the packet sum is unaffected.
- Overflow (ACC_GUARD=0, 18 beats of 255*255): without the macro the result wraps to (18*65025) mod 65536; with MUL_STAGE_SAT_EN the result is 65535.

Source files
------------

// File: rtl/mul_stage_pipe.sv
// mul_stage_pipe: N-channel c*p multiply stage with valid/ready stall and per-packet accumulate
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready = !out_valid | out_ready
//   in_mode              0 = plain multiply, 1 = multiply-accumulate
//   in_last              closes an accumulate packet (mode 1 only)
//   c_in, p_in           packed unsigned operands, channel k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready  output handshake
//   out_last             output closes an accumulate packet
//   c_out                c operands aligned with cp_out
//   cp_out               per-channel product or accumulated sum, ACC_W bits each
// Optional: define MUL_STAGE_SAT_EN to clamp accumulate overflow to all-ones instead of wrapping.
module mul_stage_pipe #(
    parameter int N_CH      = 9,
    parameter int DATA_W    = 8,
    parameter int LAT       = 2,
    parameter int ACC_GUARD = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_last,
    input  logic                                   in_mode,
    input  logic [N_CH*DATA_W-1:0]                 c_in,
    input  logic [N_CH*DATA_W-1:0]                 p_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic [N_CH*DATA_W-1:0]                 c_out,
    output logic [N_CH*(2*DATA_W+ACC_GUARD)-1:0]   cp_out
);
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = PW + ACC_GUARD;

    logic                     w_adv;
    logic [N_CH*PW-1:0]       w_prod;
    logic                     w_fv;
    logic                     w_fmode;
    logic                     w_flast;
    logic                     w_emit;
    logic [N_CH*PW-1:0]       w_fprod;
    logic [N_CH*DATA_W-1:0]   w_fc;
    logic [ACC_W:0]           w_sum;
    logic [N_CH*ACC_W-1:0]    w_acc_nxt;
    logic [N_CH*ACC_W-1:0]    w_fcp;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic                     r_in_pkt;
    logic [N_CH*DATA_W-1:0]   r_c_out;
    logic [N_CH*ACC_W-1:0]    r_cp_out;
    logic [N_CH*ACC_W-1:0]    r_acc;

    assign w_adv     = !r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign c_out     = r_c_out;
    assign cp_out    = r_cp_out;

    always_comb begin
        w_prod = '0;
        for (int k = 0; k < N_CH; k++)
            w_prod[k*PW +: PW] = PW'(c_in[k*DATA_W +: DATA_W]) * PW'(p_in[k*DATA_W +: DATA_W]);
    end

    // Since in_ready equals advance, any slot captured on an advancing edge
    // carries in_valid directly as its valid bit.
    generate
        if (LAT == 1) begin : g_lat1
            assign w_fv    = in_valid;
            assign w_fmode = in_mode;
            assign w_flast = in_last;
            assign w_fprod = w_prod;
            assign w_fc    = c_in;
        end else begin : g_latn
            logic [LAT-2:0]         r_v;
            logic [LAT-2:0]         r_mode;
            logic [LAT-2:0]         r_last;
            logic [N_CH*PW-1:0]     r_p [LAT-1];
            logic [N_CH*DATA_W-1:0] r_c [LAT-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= '0;
                end else if (w_adv) begin
                    r_v[0]    <= in_valid;
                    r_mode[0] <= in_mode;
                    r_last[0] <= in_last;
                    r_p[0]    <= w_prod;
                    r_c[0]    <= c_in;
                    for (int i = 1; i < LAT - 1; i++) begin
                        r_v[i]    <= r_v[i-1];
                        r_mode[i] <= r_mode[i-1];
                        r_last[i] <= r_last[i-1];
                        r_p[i]    <= r_p[i-1];
                        r_c[i]    <= r_c[i-1];
                    end
                end
            end
            assign w_fv    = r_v[LAT-2];
            assign w_fmode = r_mode[LAT-2];
            assign w_flast = r_last[LAT-2];
            assign w_fprod = r_p[LAT-2];
            assign w_fc    = r_c[LAT-2];
        end
    endgenerate

    // Outside a packet the accumulator base is zero. A saturated accumulator is
    // all-ones, so any further addend re-saturates it: clamping is sticky by itself.
    always_comb begin
        w_sum     = '0;
        w_acc_nxt = '0;
        w_fcp     = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, r_in_pkt ? r_acc[k*ACC_W +: ACC_W] : ACC_W'(0)} + (ACC_W+1)'(w_fprod[k*PW +: PW]);
`ifdef MUL_STAGE_SAT_EN
            w_acc_nxt[k*ACC_W +: ACC_W] = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
            w_acc_nxt[k*ACC_W +: ACC_W] = w_sum[ACC_W-1:0];
`endif
            w_fcp[k*ACC_W +: ACC_W] = w_fmode ? w_acc_nxt[k*ACC_W +: ACC_W] : ACC_W'(w_fprod[k*PW +: PW]);
        end
    end

    assign w_emit = w_fv & (!w_fmode | w_flast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_c_out     <= '0;
            r_cp_out    <= '0;
            r_acc       <= '0;
            r_in_pkt    <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_emit;
            r_out_last  <= w_emit & w_fmode;
            if (w_emit) begin
                r_c_out  <= w_fc;
                r_cp_out <= w_fcp;
            end
            if (w_fv & w_fmode) begin
                r_acc    <= w_acc_nxt;
                r_in_pkt <= !w_flast;
            end
        end
    end
endmodule

// File: tb/tb_mul_stage_pipe.sv
// tb_mul_stage_pipe: directed checks of mul_stage_pipe against a transaction-level model
module tb_mul_stage_pipe;
    localparam int N  = 9;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int BW = 16;

    typedef struct {
        logic [N*DW-1:0] c;
        logic [N*AW-1:0] cp;
        logic            last;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_last = 0;
    logic in_mode = 0;
    logic out_ready = 1;
    logic b_en = 0;
    logic [N*DW-1:0] c_in = '0;
    logic [N*DW-1:0] p_in = '0;
    logic in_ready, out_valid, out_last;
    logic [N*DW-1:0] c_out;
    logic [N*AW-1:0] cp_out;
    logic b_ready, b_valid, b_last;
    logic [N*DW-1:0] b_c;
    logic [N*BW-1:0] b_cp;

    int n_chk = 0;
    int n_pass = 0;
    exp_t q[$];
    longint m_acc[N];
    bit m_first = 1;
    exp_t m_e;
    longint m_pr;
    logic [AW-1:0] log_cp0[$];
    logic log_last[$];
    logic [N*BW-1:0] log_b[$];

    always #5 clk = ~clk;

    mul_stage_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_mode(in_mode), .c_in(c_in), .p_in(p_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .c_out(c_out), .cp_out(cp_out)
    );

    mul_stage_pipe #(.LAT(1), .ACC_GUARD(0)) u_ovf (
        .clk(clk), .rst(rst), .in_valid(in_valid & b_en), .in_ready(b_ready), .in_last(in_last),
        .in_mode(in_mode), .c_in(c_in), .p_in(p_in), .out_valid(b_valid), .out_ready(1'b1),
        .out_last(b_last), .c_out(b_c), .cp_out(b_cp)
    );

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, a, e);
    endtask

    function automatic longint fold(input longint s, input int w);
        longint lim = longint'(1) << w;
`ifdef MUL_STAGE_SAT_EN
        return (s >= lim) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    function automatic logic [N*DW-1:0] pat(input int s);
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(s * 7 + k * 13 + 1);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] v0(input int s, input int x);
        logic [N*DW-1:0] v = pat(s);
        v[DW-1:0] = DW'(x);
        return v;
    endfunction

    // Transaction model: every accepted beat is folded in by the spec's rules at acceptance.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_first = 1;
            for (int k = 0; k < N; k++) m_acc[k] = 0;
        end else if (in_valid && in_ready) begin
            m_e.c = c_in;
            m_e.cp = '0;
            m_e.last = in_mode;
            for (int k = 0; k < N; k++) begin
                m_pr = longint'(c_in[k*DW +: DW]) * longint'(p_in[k*DW +: DW]);
                if (in_mode) begin
                    m_acc[k] = fold((m_first ? 0 : m_acc[k]) + m_pr, AW);
                    m_e.cp[k*AW +: AW] = AW'(m_acc[k]);
                end else begin
                    m_e.cp[k*AW +: AW] = AW'(m_pr);
                end
            end
            if (!in_mode || in_last) q.push_back(m_e);
            if (in_mode) m_first = in_last;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", in_ready, !out_valid | out_ready);
            if (out_valid) begin
                chk("out_expected", q.size() != 0, 1);
                if (q.size() != 0) chk("out_beat", {out_last, c_out, cp_out}, {q[0].last, q[0].c, q[0].cp});
                if (out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    log_cp0.push_back(cp_out[AW-1:0]);
                    log_last.push_back(out_last);
                end
            end
            if (b_valid) log_b.push_back(b_cp);
        end
    end

    task automatic beat(input logic m, input logic l, input logic [N*DW-1:0] c, input logic [N*DW-1:0] p);
        logic ok;
        in_valid = 1;
        in_mode = m;
        in_last = l;
        c_in = c;
        p_in = p;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (t == 60) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int bb;
        logic [N*BW-1:0] eb;
        in_valid = 1;
        c_in = pat(1);
        p_in = pat(2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cp_out", cp_out, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_b_valid", b_valid, 0);
        rst = 0;
        in_valid = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        c_in = pat(3);
        c_in[7:0] = 8'd255;
        c_in[71:64] = 8'd3;
        p_in = pat(4);
        p_in[7:0] = 8'd255;
        p_in[71:64] = 8'd7;
        in_mode = 0;
        in_last = 0;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("lat_t1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_t2_valid", out_valid, 1);
        chk("m0_cp_ch0", cp_out[19:0], 65025);
        chk("m0_cp_ch8", cp_out[179:160], 21);
        chk("m0_c_ch0", c_out[7:0], 255);
        chk("m0_last", out_last, 0);
        drain();

        base = log_cp0.size();
        out_ready = 0;
        fork
            for (int i = 0; i < 5; i++) beat(0, 0, v0(10 + i, 10 + i), v0(20 + i, i + 2));
            begin
                repeat (8) @(posedge clk);
                #1;
                chk("stall_in_ready", in_ready, 0);
                chk("stall_valid", out_valid, 1);
                chk("stall_cp0", cp_out[19:0], 20);
                @(posedge clk);
                #1;
                chk("stall_frozen", cp_out[19:0], 20);
                out_ready = 1;
            end
        join
        drain();
        chk("bp_count", log_cp0.size() - base, 5);
        for (int i = 0; i < 5; i++) chk("bp_order", log_cp0[base + i], (10 + i) * (i + 2));

        base = log_cp0.size();
        beat(1, 0, v0(30, 10), v0(31, 10));
        beat(1, 0, v0(32, 20), v0(33, 3));
        beat(1, 1, v0(34, 1), v0(35, 1));
        drain();
        chk("acc_count", log_cp0.size() - base, 1);
        chk("acc_sum", log_cp0[base], 161);
        chk("acc_last", log_last[base], 1);
        beat(1, 0, v0(36, 2), v0(37, 3));
        beat(1, 1, v0(38, 4), v0(39, 5));
        drain();
        chk("acc_restart", log_cp0[base + 1], 26);

        base = log_cp0.size();
        beat(1, 0, v0(40, 10), v0(41, 10));
        beat(0, 0, v0(42, 4), v0(43, 5));
        beat(1, 0, v0(44, 20), v0(45, 3));
        beat(1, 1, v0(46, 1), v0(47, 1));
        drain();
        chk("il_count", log_cp0.size() - base, 2);
        chk("il_plain", log_cp0[base], 20);
        chk("il_plain_last", log_last[base], 0);
        chk("il_sum", log_cp0[base + 1], 161);

        base = log_cp0.size();
        beat(1, 0, v0(50, 9), v0(51, 9));
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        beat(1, 1, v0(52, 2), v0(53, 3));
        drain();
        chk("rst_abandon", log_cp0[base], 6);

        base = log_cp0.size();
        bb = log_b.size();
        b_en = 1;
        for (int i = 0; i < 18; i++) beat(1, i == 17, {N{8'd255}}, {N{8'd255}});
        b_en = 0;
        drain();
        chk("ovf_count", log_cp0.size() - base, 1);
        chk("ovf_b_count", log_b.size() - bb, 1);
`ifdef MUL_STAGE_SAT_EN
        chk("ovf_a", log_cp0[base], 1048575);
        eb = {N{16'hFFFF}};
`else
        chk("ovf_a", log_cp0[base], 121874);
        eb = {N{16'd56338}};
`endif
        if (log_b.size() > bb) chk("ovf_b", log_b[bb], eb);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
